hct138_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 74LS138-style 3-to-8 decoder among 8 requesters.
- Drives the decoder's select lines (C,B,A) and its three enables (G, G_2A, G_2B) so that exactly one requester at a time sees an active-low select.
- Also outputs the decoded active-low grant vector directly, for checking against the decoder output.
- Sits between requesting blocks (display digits, chip-selects, peripherals) and the shared HCT138 decode stage.

---
 rtl/hct138_rr_sched_if.sv | 30 +++
 rtl/hct138_rr_sched.sv | 193 +++++++++++++++++++
 tb/tb_hct138_rr_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hct138_rr_sched_if.sv
// Bundle of signals between the round-robin scheduler and its users:
// enable/request inputs and the shared 74HCT138 decoder drive
// (select, enables, expected active-low grant, status).
interface hct138_rr_sched_if;
  localparam int unsigned N_REQ = 8;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             C;
  logic             B;
  logic             A;
  logic             G;
  logic             G_2A;
  logic             G_2B;
  logic [N_REQ-1:0] y_n;
  logic             busy;
  logic             timeout;

  // Requesting side: drives enable/requests, observes the decoder drive.
  modport master (
    output en, req,
    input  C, B, A, G, G_2A, G_2B, y_n, busy, timeout
  );

  // Scheduler side.
  modport slave (
    input  en, req,
    output C, B, A, G, G_2A, G_2B, y_n, busy, timeout
  );
endinterface

// File: rtl/hct138_rr_sched.sv
// Round-robin scheduler sharing one 74HCT138 3-to-8 decoder among 8 requesters.
// Optional macro HCT138_RR_TIMEOUT_EN enables the MAX_HOLD forced release and
// the one-cycle timeout pulse; without it a grant ends only on req drop or en=0.
module hct138_rr_sched #(
  parameter int unsigned MAX_HOLD   = 15,
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  hct138_rr_sched_if.slave  bus
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned GAP_W  = 4;

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [N_REQ-1:0] ALL_OFF  = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Parameter range guards, evaluated at elaboration only.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("hct138_rr_sched: MAX_HOLD must be in 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("hct138_rr_sched: GAP_CYCLES must be in 1..15");
  end

  logic [1:0]       state, state_nx;
  logic [IDX_W-1:0] sel, sel_nx;
  logic [IDX_W-1:0] last, last_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             g_q, g2a_q, g2b_q;
  logic             dec_on_nx;
  logic [N_REQ-1:0] y_n_q, y_n_nx;
  logic             busy_q, busy_nx;

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] winner;
  logic             grant_go;
  logic             keep_ok;
  logic             hold_hit;
  logic             take;

  // Requests rotated so that bit 0 is the requester just after 'last'.
  always_comb begin
    rot = '0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      rot[j] = bus.req[last + IDX_W'(j) + IDX_W'(1)];
    end
  end

  // Lowest set bit of the rotated vector is the nearest requester after 'last'.
  always_comb begin
    off = '0;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
  end

  assign winner   = last + IDX_W'(1) + off;
  assign grant_go = bus.en && (|bus.req);
  assign keep_ok  = bus.en && bus.req[last];

`ifdef HCT138_RR_TIMEOUT_EN
  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX_CNT = '1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD));

  // Cycles spent in the current grant, loaded on grant entry, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != ST_GRANT && state_nx == ST_GRANT) begin
      hold_cnt <= HOLD_W'(1);
    end else if (state == ST_GRANT && state_nx == ST_GRANT && hold_cnt != HOLD_MAX_CNT) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Timeout pulses only when the hold limit alone ends the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == ST_GRANT) && keep_ok && hold_hit;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign hold_hit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    last_nx   = last;
    gap_nx    = gap_cnt;
    dec_on_nx = 1'b0;
    y_n_nx    = ALL_OFF;
    busy_nx   = 1'b0;
    take      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (grant_go) take = 1'b1;
      end
      ST_GRANT: begin
        if (!keep_ok || hold_hit) begin
          state_nx = ST_GAP;
          gap_nx   = GAP_W'(1);
        end else begin
          dec_on_nx = 1'b1;
          y_n_nx    = ~(ONE_HOT0 << sel);
          busy_nx   = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
          if (grant_go) take = 1'b1;
          else          state_nx = ST_IDLE;
        end else begin
          gap_nx = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (take) begin
      state_nx  = ST_GRANT;
      sel_nx    = winner;
      last_nx   = winner;
      dec_on_nx = 1'b1;
      y_n_nx    = ~(ONE_HOT0 << winner);
      busy_nx   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered decoder drive and bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel     <= '0;
      last    <= IDX_W'(N_REQ - 1);
      gap_cnt <= '0;
      g_q     <= 1'b0;
      g2a_q   <= 1'b1;
      g2b_q   <= 1'b1;
      y_n_q   <= ALL_OFF;
      busy_q  <= 1'b0;
    end else begin
      sel     <= sel_nx;
      last    <= last_nx;
      gap_cnt <= gap_nx;
      g_q     <= dec_on_nx;
      g2a_q   <= !dec_on_nx;
      g2b_q   <= !dec_on_nx;
      y_n_q   <= y_n_nx;
      busy_q  <= busy_nx;
    end
  end

  assign bus.C    = sel[2];
  assign bus.B    = sel[1];
  assign bus.A    = sel[0];
  assign bus.G    = g_q;
  assign bus.G_2A = g2a_q;
  assign bus.G_2B = g2b_q;
  assign bus.y_n  = y_n_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_hct138_rr_sched.sv
// Randomised and directed bench for hct138_rr_sched with a scoreboard queue
// fed by a behavioural round-robin model.
module tb_hct138_rr_sched;

  localparam int unsigned MAX_HOLD   = 4;
  localparam int unsigned GAP_CYCLES = 2;
`ifdef HCT138_RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic       g;
    logic       g2a;
    logic       g2b;
    logic [7:0] y_n;
    logic       busy;
    logic       timeout;
  } obs_t;

  logic clk;
  logic rst_n;
  hct138_rr_sched_if bus();

  hct138_rr_sched #(
    .MAX_HOLD  (MAX_HOLD),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   vectors     = 0;
  int   miscompares = 0;

  // Model: who holds the decoder (-1 = nobody), how long, and the gap progress.
  int       m_cur    = -1;
  int       m_last   = 7;
  int       m_held   = 0;
  bit       m_in_gap = 1'b0;
  int       m_gap_el = 0;
  logic [2:0] m_sel  = 3'd0;
  bit       m_to     = 1'b0;

  logic [7:0] stim_q;
  bit         stim_e;
  bit         stim_r;

  task automatic try_grant(input bit e, input logic [7:0] q);
    int i;
    if (e && q != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        i = (m_last + k) % 8;
        if (q[i]) begin
          m_cur  = i;
          m_last = i;
          m_sel  = 3'(i);
          m_held = 1;
          break;
        end
      end
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [7:0] q);
    bit drop, hit;
    m_to = 1'b0;
    if (!r) begin
      m_cur = -1; m_last = 7; m_held = 0; m_in_gap = 1'b0; m_gap_el = 0; m_sel = 3'd0;
    end else if (m_cur >= 0) begin
      drop = !q[m_cur] || !e;
      hit  = TO_EN && (m_held == int'(MAX_HOLD));
      if (drop || hit) begin
        m_to     = hit && !drop;
        m_cur    = -1;
        m_in_gap = 1'b1;
        m_gap_el = 1;
      end else if (m_held < 255) begin
        m_held++;
      end
    end else if (m_in_gap) begin
      if (m_gap_el == int'(GAP_CYCLES)) begin
        m_in_gap = 1'b0;
        try_grant(e, q);
      end else begin
        m_gap_el++;
      end
    end else begin
      try_grant(e, q);
    end
  endtask

  function automatic obs_t expected();
    obs_t o;
    logic [7:0] one;
    bit on;
    one       = 8'h01;
    on        = (m_cur >= 0);
    o.sel     = m_sel;
    o.g       = on;
    o.g2a     = !on;
    o.g2b     = !on;
    o.y_n     = on ? ~(one << m_cur) : 8'hFF;
    o.busy    = on;
    o.timeout = m_to;
    return o;
  endfunction

  // Apply one cycle of inputs, push the response expected after the next edge.
  task automatic cyc(input bit r, input bit e, input logic [7:0] q);
    rst_n   = r;
    bus.en  = e;
    bus.req = q;
    model_step(r, e, q);
    exp_q.push_back(expected());
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {bus.C, bus.B, bus.A, bus.G, bus.G_2A, bus.G_2B, bus.y_n, bus.busy, bus.timeout};
        vectors++;
        if (mon_a !== mon_e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got sel=%0d G/2A/2B=%b%b%b y_n=%h busy=%b timeout=%b, want sel=%0d G/2A/2B=%b%b%b y_n=%h busy=%b timeout=%b",
                   $time, mon_a.sel, mon_a.g, mon_a.g2a, mon_a.g2b, mon_a.y_n, mon_a.busy, mon_a.timeout,
                   mon_e.sel, mon_e.g, mon_e.g2a, mon_e.g2b, mon_e.y_n, mon_e.busy, mon_e.timeout);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.req = 8'h00;

    // Reset with all requests pending, then release.
    repeat (3) cyc(1'b0, 1'b1, 8'hFF);
    repeat (4) cyc(1'b1, 1'b1, 8'hFF);
    repeat (2) cyc(1'b0, 1'b1, 8'h00);

    // Single requester 5.
    repeat (4) cyc(1'b1, 1'b1, 8'h20);
    repeat (6) cyc(1'b1, 1'b1, 8'h00);

    // Full round robin: each winner drops its bit two cycles into its grant.
    for (int n = 0; n < 50; n++) begin
      stim_q = 8'hFF;
      if (m_cur >= 0 && m_held >= 2) stim_q[m_cur] = 1'b0;
      cyc(1'b1, 1'b1, stim_q);
    end
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Two requesters held constantly (forced release when enabled).
    repeat (24) cyc(1'b1, 1'b1, 8'h09);
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Request drop coinciding with the hold limit.
    for (int n = 0; n < 14; n++) begin
      stim_q = (m_cur == 0 && m_held == int'(MAX_HOLD)) ? 8'h00 : 8'h01;
      cyc(1'b1, 1'b1, stim_q);
    end
    // Enable drop coinciding with the hold limit.
    for (int n = 0; n < 14; n++) begin
      stim_e = !(m_cur == 0 && m_held == int'(MAX_HOLD));
      cyc(1'b1, stim_e, 8'h01);
    end
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Enable override mid-grant of requester 2.
    repeat (3) cyc(1'b1, 1'b1, 8'h04);
    repeat (4) cyc(1'b1, 1'b0, 8'h04);
    repeat (4) cyc(1'b1, 1'b1, 8'h04);
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Reset while requester 6 is granted.
    repeat (3) cyc(1'b1, 1'b1, 8'hC0);
    cyc(1'b0, 1'b1, 8'hC0);
    repeat (5) cyc(1'b1, 1'b1, 8'hC0);
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Random traffic with sticky requests, occasional en drop and reset.
    stim_q = 8'h00;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) == 0) stim_q = 8'($urandom);
      stim_e = ($urandom_range(15) != 0);
      stim_r = ($urandom_range(63) != 0);
      cyc(stim_r, stim_e, stim_q);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending responses, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
